uart_tx: RTL
============

Name: uart_tx

Overview:
- UART transmitter, the outbound counterpart of the board's UART receive path; drives uart_txd_o at the top-level wrapper.
- Accepts bytes over a valid/ready handshake into a small FIFO.
- Serialises each byte as: 1 start bit, 8 data bits LSB-first, optional parity bit, 1 or 2 stop bits. Line format matches the receive path: 57600 baud, even parity, 1 stop bit.
- Runs in the 200 MHz system clock domain.

Parameters:
- CLK_FREQ, 200000000, system clock frequency in Hz.
- BAUD, 57600, line rate in bit/s. Bit period DIV = round(CLK_FREQ/BAUD) = 3472 cycles at the defaults.
- PARITY_EN, 1, 1 = insert parity bit, 0 = no parity bit.
- PARITY_ODD, 0, 0 = even parity, 1 = odd parity. Ignored when PARITY_EN = 0.
- STOP_BITS, 1, number of stop bits, 1 or 2.
- FIFO_AW, 2, FIFO address width. Depth = 2**FIFO_AW = 4.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- data_i  in  8  byte to transmit.
- valid_i  in  1  data_i is valid.
- ready_o  out  1  FIFO can accept a byte.
- txd_o  out  1  serial line output; idle high.
- busy_o  out  1  frame in progress or FIFO non-empty.
- fifo_cnt_o  out  FIFO_AW+1  current FIFO occupancy.

Behaviour:
- Reset (rst = 0, asynchronous):
  - txd_o = 1, ready_o = 1, busy_o = 0, fifo_cnt_o = 0.
  - FSM goes to IDLE; FIFO pointers and baud counter clear.
  - Reset mid-frame aborts the frame immediately: the line returns high and the queued bytes are discarded.
- Handshake:
  - A byte is accepted on a rising edge where valid_i and ready_o are both 1.
  - ready_o = (fifo_cnt_o < depth). It is registered-equivalent, combinational from the counter only, and has no path from valid_i.
  - data_i is sampled at the accept edge and may change afterwards.
  - Pushing while full is impossible (ready_o = 0). A push and a pop in the same cycle leave fifo_cnt_o unchanged.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: txd_o = 1. If the FIFO is non-empty: pop the head into the shift register, load the baud counter with DIV-1, go to START.
  - START: txd_o = 0 for DIV cycles, then go to DATA with bit index 0.
  - DATA: txd_o = shift[0] for DIV cycles, then shift right and increment the index. After index 7 completes, go to PARITY if PARITY_EN, else STOP.
  - PARITY: txd_o = XOR of the 8 data bits, XOR PARITY_ODD, for DIV cycles.
  - STOP: txd_o = 1 for STOP_BITS*DIV cycles. At the end, if the FIFO is non-empty, pop and go directly to START with no idle gap; otherwise go to IDLE.
- Latency: a byte accepted at edge N into an empty FIFO with the FSM in IDLE drives txd_o low after edge N+1.
- Timing: every bit lasts exactly DIV cycles (0 cycles of jitter). Frame length = (10 + PARITY_EN + STOP_BITS - 1) * DIV cycles; 11*3472 = 38192 at the defaults.
- Baud counter: counts down from DIV-1 to 0, reloads on each bit boundary, and is held at 0 in IDLE.
- busy_o = (state != IDLE) or (fifo_cnt_o != 0).
- valid_i held high with the FIFO empty and the FSM idle: bytes stream back-to-back, and each stop bit is followed immediately by the next start bit.

Test Plan:
1. Push 0x68 once after reset release -> txd_o falls 1 cycle after the accept edge. Line sequence 0,0,0,0,1,0,1,1,0,1,1 (start, LSB-first data, parity = 1, stop), each bit exactly 3472 cycles. busy_o falls 38192 cycles after the start bit.
2. Push 0x68 and 0x69 on consecutive cycles -> two contiguous frames. The second start edge comes exactly 38192 cycles after the first. The 0x69 parity bit = 0.
3. Hold valid_i high with 6 bytes while the first frame is active -> 1 byte popped and 4 queued. ready_o = 0 while fifo_cnt_o = 4. The 6th byte is accepted only after the next pop. All 6 bytes appear on the line in order.
4. Assert rst low mid-DATA with 3 bytes queued -> txd_o = 1 and fifo_cnt_o = 0 in the same cycle. After release, no frame is sent until a new push.
5. PARITY_ODD = 1, STOP_BITS = 2, push 0x0F -> parity bit = 1, followed by 2*3472 cycles high.
6. Loop txd_o into the existing UART receive path and send 0x31, 0x39, 0x32 ("192") -> the receiver reports the same three bytes with no parity or framing errors.

Source files
------------

// File: rtl/uart_tx.sv
// UART transmitter: valid/ready byte intake into a small FIFO, framed as
// start + 8 data (LSB first) + optional parity + 1 or 2 stop bits.
module uart_tx #(
  parameter int unsigned CLK_FREQ   = 200000000,
  parameter int unsigned BAUD       = 57600,
  parameter int unsigned PARITY_EN  = 1,
  parameter int unsigned PARITY_ODD = 0,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned FIFO_AW    = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [7:0]         data_i,
  input  logic               valid_i,
  output logic               ready_o,
  output logic               txd_o,
  output logic               busy_o,
  output logic [FIFO_AW:0]   fifo_cnt_o
);

  localparam int unsigned DIV   = (CLK_FREQ + BAUD / 2) / BAUD;
  localparam int unsigned CW    = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned DEPTH = 1 << FIFO_AW;
  localparam logic [CW-1:0]    BAUD_RELOAD = CW'(DIV - 1);
  localparam logic [FIFO_AW:0] FULL_CNT    = (FIFO_AW + 1)'(DEPTH);
  localparam logic             PAR_ODD     = (PARITY_ODD != 0);
  localparam logic             STOP_EXTRA  = (STOP_BITS == 2);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  logic [7:0]         mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
  logic [FIFO_AW:0]   cnt;
  logic               push, pop;
  logic [7:0]         head;

  state_t        state, state_n;
  logic [CW-1:0] baud_cnt, baud_n;
  logic [2:0]    bit_idx, idx_n;
  logic [7:0]    shift, shift_n;
  logic          par_bit, par_n;
  logic          stop_left, stop_n;
  logic          txd_q, txd_n;

  assign ready_o    = (cnt < FULL_CNT);
  assign push       = valid_i & ready_o;
  assign head       = mem[rd_ptr];
  assign fifo_cnt_o = cnt;
  assign busy_o     = (state != IDLE) || (cnt != '0);
  assign txd_o      = txd_q;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= data_i;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      baud_cnt  <= '0;
      bit_idx   <= '0;
      shift     <= '0;
      par_bit   <= 1'b0;
      stop_left <= 1'b0;
      txd_q     <= 1'b1;
    end else begin
      state     <= state_n;
      baud_cnt  <= baud_n;
      bit_idx   <= idx_n;
      shift     <= shift_n;
      par_bit   <= par_n;
      stop_left <= stop_n;
      txd_q     <= txd_n;
    end
  end

  always_comb begin
    state_n = state;
    baud_n  = baud_cnt;
    idx_n   = bit_idx;
    shift_n = shift;
    par_n   = par_bit;
    stop_n  = stop_left;
    pop     = 1'b0;
    case (state)
      IDLE: begin
        baud_n = '0;
        if (cnt != '0) begin
          pop     = 1'b1;
          shift_n = head;
          par_n   = (^head) ^ PAR_ODD;
          baud_n  = BAUD_RELOAD;
          state_n = START;
        end
      end
      START: begin
        if (baud_cnt == '0) begin
          baud_n  = BAUD_RELOAD;
          idx_n   = '0;
          state_n = DATA;
        end else begin
          baud_n = baud_cnt - 1'b1;
        end
      end
      DATA: begin
        if (baud_cnt == '0) begin
          baud_n  = BAUD_RELOAD;
          shift_n = shift >> 1;
          idx_n   = bit_idx + 3'd1;
          if (bit_idx == 3'd7) begin
            stop_n  = STOP_EXTRA;
            state_n = (PARITY_EN != 0) ? PARITY : STOP;
          end
        end else begin
          baud_n = baud_cnt - 1'b1;
        end
      end
      PARITY: begin
        if (baud_cnt == '0) begin
          baud_n  = BAUD_RELOAD;
          stop_n  = STOP_EXTRA;
          state_n = STOP;
        end else begin
          baud_n = baud_cnt - 1'b1;
        end
      end
      STOP: begin
        if (baud_cnt != '0) begin
          baud_n = baud_cnt - 1'b1;
        end else if (stop_left) begin
          stop_n = 1'b0;
          baud_n = BAUD_RELOAD;
        end else if (cnt != '0) begin
          // chain straight into the next start bit, no idle cycle
          pop     = 1'b1;
          shift_n = head;
          par_n   = (^head) ^ PAR_ODD;
          baud_n  = BAUD_RELOAD;
          state_n = START;
        end else begin
          baud_n  = '0;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase

    // line is registered from the next state so it changes exactly on bit edges
    case (state_n)
      START:   txd_n = 1'b0;
      DATA:    txd_n = shift_n[0];
      PARITY:  txd_n = par_n;
      default: txd_n = 1'b1;
    endcase
  end

endmodule
